// File: rtl/qracc_pkg.sv
// Shared types and sizing for the accumulator requantizer.
// Optional ReLU clamp is selected by the QRACC_OUT_RELU_EN macro.
package qracc_pkg;
   localparam int OUTPUT_ELEMENTS = 32;
   localparam int ACC_BITS        = 16;
   localparam int OUT_BITS        = 8;
   localparam int LANES_PER_BEAT  = 4;
   localparam int SCALE_W         = 8;
   localparam int SHIFT_W         = 4;
   localparam int NUM_BEATS       = OUTPUT_ELEMENTS / LANES_PER_BEAT;
   localparam int BEAT_W          = $clog2(NUM_BEATS);
   localparam int PROD_W          = ACC_BITS + SCALE_W + 1;

   typedef struct packed {
      logic [SCALE_W-1:0]         scale;
      logic [SHIFT_W-1:0]         shift;
      logic signed [OUT_BITS-1:0] zero_point;
   } requant_cfg_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;
endpackage

// File: rtl/requant_lane.sv
// Combinational single-lane requantizer: multiply, rounding shift, zero-point, saturate.
// With QRACC_OUT_RELU_EN defined, negative results are clamped to zero.
module requant_lane
   import qracc_pkg::*;
(
   input  logic [ACC_BITS-1:0] acc_i,
   input  requant_cfg_t        cfg_i,
   output logic [OUT_BITS-1:0] res_o
);
   // Two guard bits above the product keep rounding and offset from wrapping.
   localparam int SUM_W = PROD_W + 2;

   logic signed [PROD_W-1:0] acc_x;
   logic signed [PROD_W-1:0] scale_x;
   logic signed [PROD_W-1:0] prod;
   logic signed [SUM_W-1:0]  rnd;
   logic signed [SUM_W-1:0]  sum;
   logic signed [SUM_W-1:0]  rounded;
   logic signed [SUM_W-1:0]  offset;
   logic [SUM_W-OUT_BITS:0]  upper;

   always_comb begin
      acc_x   = {{(PROD_W-ACC_BITS){acc_i[ACC_BITS-1]}}, acc_i};
      scale_x = {{(PROD_W-SCALE_W){1'b0}}, cfg_i.scale};
      prod    = acc_x * scale_x;
      rnd     = '0;
      if (cfg_i.shift != '0) begin
         rnd[cfg_i.shift - 4'd1] = 1'b1;
      end
      sum     = $signed({{2{prod[PROD_W-1]}}, prod}) + rnd;
      rounded = sum >>> cfg_i.shift;
      offset  = rounded + $signed({{(SUM_W-OUT_BITS){cfg_i.zero_point[OUT_BITS-1]}},
                                   cfg_i.zero_point});
      upper   = offset[SUM_W-1:OUT_BITS-1];
      if ((&upper) || (~|upper)) begin
         res_o = offset[OUT_BITS-1:0];
      end else if (offset[SUM_W-1]) begin
         res_o = {1'b1, {(OUT_BITS-1){1'b0}}};
      end else begin
         res_o = {1'b0, {(OUT_BITS-1){1'b1}}};
      end
`ifdef QRACC_OUT_RELU_EN
      if (res_o[OUT_BITS-1]) begin
         res_o = '0;
      end
`endif
   end
endmodule

// File: rtl/qracc_out_requant.sv
// Captures an accumulator vector and streams it requantized, LANES_PER_BEAT lanes per beat.
// Latency 2 cycles pulse-to-first-beat; holds beats under !out_ready_i; drops vectors when busy (sticky overflow). Optional ReLU: QRACC_OUT_RELU_EN.
module qracc_out_requant
   import qracc_pkg::*;
(
   input  logic                                           clk,
   input  logic                                           nrst,
   input  requant_cfg_t                                   cfg_i,
   input  logic [OUTPUT_ELEMENTS-1:0][ACC_BITS-1:0]       acc_data_i,
   input  logic                                           acc_valid_i,
   output logic                                           acc_ready_o,
   output logic [LANES_PER_BEAT-1:0][OUT_BITS-1:0]        out_data_o,
   output logic                                           out_valid_o,
   input  logic                                           out_ready_i,
   output logic                                           out_last_o,
   output logic                                           overflow_o
);
   // Buffer is reshaped beat-major so a beat's lanes are a single index.
   typedef logic [NUM_BEATS-1:0][LANES_PER_BEAT-1:0][ACC_BITS-1:0] vbuf_t;

   state_t                                 state_q, state_d;
   logic [BEAT_W-1:0]                      beat_q, beat_d;
   vbuf_t                                  buf_q, buf_d;
   requant_cfg_t                           cfg_q, cfg_d;
   logic [LANES_PER_BEAT-1:0][OUT_BITS-1:0] data_q, data_d, lane_res;
   logic                                   valid_q, valid_d;
   logic                                   last_q, last_d;
   logic                                   ovf_q, ovf_d;
   logic                                   load, final_load, capture;

   for (genvar g = 0; g < LANES_PER_BEAT; g++) begin : g_lane
      requant_lane u_lane (
         .acc_i (buf_q[beat_q][g]),
         .cfg_i (cfg_q),
         .res_o (lane_res[g])
      );
   end

   assign load        = (state_q == ST_SEND) && (!valid_q || out_ready_i);
   assign final_load  = load && (beat_q == BEAT_W'(NUM_BEATS-1));
   assign acc_ready_o = (state_q == ST_IDLE) || final_load;
   assign capture     = acc_valid_i && acc_ready_o;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      buf_d   = buf_q;
      cfg_d   = cfg_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      ovf_d   = ovf_q || (acc_valid_i && !acc_ready_o);
      if (load) begin
         data_d  = lane_res;
         valid_d = 1'b1;
         last_d  = final_load;
         beat_d  = final_load ? '0 : beat_q + 1'b1;
         if (final_load) begin
            state_d = ST_IDLE;
         end
      end else if (valid_q && out_ready_i) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
      // A capture in the final-load cycle overrides the return to IDLE.
      if (capture) begin
         buf_d   = vbuf_t'(acc_data_i);
         cfg_d   = cfg_i;
         beat_d  = '0;
         state_d = ST_SEND;
      end
   end

   always_ff @(posedge clk) begin
      if (nrst) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         buf_q   <= '0;
         cfg_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         buf_q   <= buf_d;
         cfg_q   <= cfg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out_data_o  = data_q;
   assign out_valid_o = valid_q;
   assign out_last_o  = last_q;
   assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_qracc_out_requant.sv
// Directed bench for qracc_out_requant: arithmetic vector table plus stream corner sequences.
// Expected values follow QRACC_OUT_RELU_EN when it is defined for the build.
module tb_qracc_out_requant;
   import qracc_pkg::*;

   typedef logic [OUTPUT_ELEMENTS-1:0][ACC_BITS-1:0] vec_t;
   typedef struct {
      logic signed [15:0] acc;
      logic [7:0]         scale;
      logic [3:0]         shift;
      logic signed [7:0]  zp;
      int                 expv;
   } rec_t;

`ifdef QRACC_OUT_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif
   localparam int NREC = 15;

   logic                                    clk = 1'b0;
   logic                                    nrst;
   requant_cfg_t                            cfg_i;
   vec_t                                    acc_data_i;
   logic                                    acc_valid_i;
   logic                                    acc_ready_o;
   logic [LANES_PER_BEAT-1:0][OUT_BITS-1:0] out_data_o;
   logic                                    out_valid_o;
   logic                                    out_ready_i;
   logic                                    out_last_o;
   logic                                    overflow_o;

   int vecs = 0;
   int errs = 0;
   rec_t tbl [NREC];

   qracc_out_requant dut (
      .clk         (clk),
      .nrst        (nrst),
      .cfg_i       (cfg_i),
      .acc_data_i  (acc_data_i),
      .acc_valid_i (acc_valid_i),
      .acc_ready_o (acc_ready_o),
      .out_data_o  (out_data_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_last_o  (out_last_o),
      .overflow_o  (overflow_o)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t fill(input logic [15:0] a);
      vec_t v;
      for (int i = 0; i < OUTPUT_ELEMENTS; i++) v[i] = a;
      return v;
   endfunction

   function automatic vec_t ramp(input int base);
      vec_t v;
      for (int i = 0; i < OUTPUT_ELEMENTS; i++) v[i] = 16'(base + i);
      return v;
   endfunction

   function automatic logic [31:0] beat_exp(input int base, input int b);
      logic [31:0] r;
      for (int l = 0; l < LANES_PER_BEAT; l++) r[l*8 +: 8] = 8'(base + 4*b + l);
      return r;
   endfunction

   // Config and data are scrambled after the pulse: only the captured copy may be used.
   task automatic pulse(input vec_t d, input logic [7:0] sc, input logic [3:0] sh,
                        input logic [7:0] zp);
      acc_data_i = d;
      cfg_i.scale = sc;
      cfg_i.shift = sh;
      cfg_i.zero_point = zp;
      acc_valid_i = 1'b1;
      tick;
      acc_valid_i = 1'b0;
      acc_data_i = '1;
      cfg_i = '1;
   endtask

   initial begin
      int beats, cyc, first, stall, gaps, e;
      logic [31:0] expw;

      tbl[0]  = '{16'sd100,    8'd64,  4'd6,  8'sd0,    100};
      tbl[1]  = '{16'sd1000,   8'd1,   4'd0,  8'sd0,    127};
      tbl[2]  = '{-16'sd1000,  8'd1,   4'd0,  8'sd0,   -128};
      tbl[3]  = '{-16'sd3,     8'd1,   4'd1,  8'sd0,     -1};
      tbl[4]  = '{16'sd3,      8'd1,   4'd1,  8'sd0,      2};
      tbl[5]  = '{16'sd5,      8'd1,   4'd0, -8'sd10,    -5};
      tbl[6]  = '{-16'sd100,   8'd64,  4'd6,  8'sd0,   -100};
      tbl[7]  = '{16'sd7,      8'd255, 4'd4,  8'sd20,   127};
      tbl[8]  = '{16'sd1,      8'd1,   4'd1,  8'sd0,      1};
      tbl[9]  = '{-16'sd1,     8'd1,   4'd1,  8'sd0,      0};
      tbl[10] = '{16'sd32767,  8'd255, 4'd15, 8'sd0,    127};
      tbl[11] = '{-16'sd32768, 8'd255, 4'd0,  8'sd0,   -128};
      tbl[12] = '{16'sd10,     8'd3,   4'd0,  8'sd100,  127};
      tbl[13] = '{-16'sd50,    8'd2,   4'd0, -8'sd100, -128};
      tbl[14] = '{16'sd0,      8'd0,   4'd0, -8'sd5,     -5};

      nrst = 1'b1;
      cfg_i = '0;
      acc_data_i = '0;
      acc_valid_i = 1'b0;
      out_ready_i = 1'b1;
      repeat (3) tick;
      nrst = 1'b0;
      chk("rst_valid", out_valid_o, 0);
      chk("rst_ready", acc_ready_o, 1);
      chk("rst_ovf", overflow_o, 0);
      chk("rst_last", out_last_o, 0);
      chk("rst_data", out_data_o, 0);

      for (int i = 0; i < NREC; i++) begin
         e = (RELU && tbl[i].expv < 0) ? 0 : tbl[i].expv;
         expw = {4{8'(e)}};
         pulse(fill(tbl[i].acc), tbl[i].scale, tbl[i].shift, tbl[i].zp);
         chk($sformatf("v%0d_lat0", i), out_valid_o, 0);
         beats = 0; cyc = 0; first = -1;
         while (beats < NUM_BEATS && cyc < 40) begin
            if (out_valid_o) begin
               if (beats == 0) first = cyc;
               chk($sformatf("v%0d_b%0d_data", i, beats), out_data_o, expw);
               chk($sformatf("v%0d_b%0d_last", i, beats), out_last_o, beats == NUM_BEATS-1);
               beats++;
            end
            tick;
            cyc++;
         end
         chk($sformatf("v%0d_latency", i), first, 1);
         chk($sformatf("v%0d_beats", i), beats, NUM_BEATS);
         chk($sformatf("v%0d_idle", i), out_valid_o, 0);
      end

      // Backpressure for 5 cycles while beat 3 is presented.
      pulse(ramp(0), 8'd1, 4'd0, 8'd0);
      beats = 0; stall = 0; cyc = 0;
      while (beats < NUM_BEATS && cyc < 60) begin
         out_ready_i = (beats == 3 && stall < 5) ? 1'b0 : 1'b1;
         if (out_valid_o) begin
            chk($sformatf("bp_b%0d_data", beats), out_data_o, beat_exp(0, beats));
            if (out_ready_i) beats++;
            else stall++;
         end
         tick;
         cyc++;
      end
      out_ready_i = 1'b1;
      chk("bp_beats", beats, NUM_BEATS);
      chk("bp_stall", stall, 5);
      chk("bp_cycles", cyc, 14);
      chk("bp_idle", out_valid_o, 0);

      // Pulse while busy at beat 2 is dropped and flags overflow.
      pulse(ramp(20), 8'd1, 4'd0, 8'd0);
      beats = 0; cyc = 0;
      while (beats < NUM_BEATS && cyc < 40) begin
         if (out_valid_o) begin
            chk($sformatf("ov_b%0d_data", beats), out_data_o, beat_exp(20, beats));
            if (beats == 2) begin
               chk("ov_rdy", acc_ready_o, 0);
               acc_data_i = ramp(50);
               acc_valid_i = 1'b1;
            end
            beats++;
         end
         tick;
         acc_valid_i = 1'b0;
         cyc++;
      end
      chk("ov_beats", beats, NUM_BEATS);
      chk("ov_flag", overflow_o, 1);
      repeat (3) tick;
      chk("ov_sticky", overflow_o, 1);
      chk("ov_no_emit", out_valid_o, 0);

      // Pulse in the final-load cycle is accepted with no bubble.
      pulse(ramp(0), 8'd1, 4'd0, 8'd0);
      beats = 0; cyc = 0; gaps = 0;
      while (beats < 2*NUM_BEATS && cyc < 60) begin
         if (out_valid_o) begin
            chk($sformatf("bb_b%0d_data", beats), out_data_o,
                beats < NUM_BEATS ? beat_exp(0, beats) : beat_exp(32, beats - NUM_BEATS));
            chk($sformatf("bb_b%0d_last", beats), out_last_o,
                beats == NUM_BEATS-1 || beats == 2*NUM_BEATS-1);
            if (beats == NUM_BEATS-2) begin
               chk("bb_rdy", acc_ready_o, 1);
               acc_data_i = ramp(32);
               cfg_i.scale = 8'd1;
               cfg_i.shift = 4'd0;
               cfg_i.zero_point = 8'd0;
               acc_valid_i = 1'b1;
            end
            beats++;
         end else if (beats > 0) begin
            gaps++;
         end
         tick;
         acc_valid_i = 1'b0;
         cyc++;
      end
      chk("bb_beats", beats, 2*NUM_BEATS);
      chk("bb_gaps", gaps, 0);

      // Reset while beat 4 is presented discards the rest of the burst.
      pulse(ramp(0), 8'd1, 4'd0, 8'd0);
      beats = 0; cyc = 0;
      while (beats < 4 && cyc < 40) begin
         if (out_valid_o) beats++;
         tick;
         cyc++;
      end
      chk("rs_b4_valid", out_valid_o, 1);
      chk("rs_b4_data", out_data_o, beat_exp(0, 4));
      nrst = 1'b1;
      tick;
      nrst = 1'b0;
      chk("rs_valid", out_valid_o, 0);
      chk("rs_ready", acc_ready_o, 1);
      chk("rs_ovf", overflow_o, 0);
      chk("rs_data", out_data_o, 0);
      pulse(ramp(64), 8'd1, 4'd0, 8'd0);
      beats = 0; cyc = 0;
      while (beats < NUM_BEATS && cyc < 40) begin
         if (out_valid_o) begin
            chk($sformatf("rs_b%0d_data", beats), out_data_o, beat_exp(64, beats));
            beats++;
         end
         tick;
         cyc++;
      end
      chk("rs_beats", beats, NUM_BEATS);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
